// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one-hot registered grant, per-requester credits
// refilled from programmable weights. Define WRR_STATS_EN to add grant/reload counters.

module wrr_lane #(
    parameter int WEIGHT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic [WEIGHT_W-1:0] wr_data,
    input  logic                reload,
    input  logic                charge,
    output logic [WEIGHT_W-1:0] weight,
    output logic [WEIGHT_W-1:0] credit
);
    always_ff @(posedge clk) begin
        if (rst) begin
            weight <= WEIGHT_W'(1);
            credit <= WEIGHT_W'(1);
        end else begin
            if (wr)
                weight <= wr_data;
            // A write landing on the reload cycle goes straight into the credit.
            if (reload)
                credit <= wr ? wr_data : weight;
            else if (charge && credit != '0)
                credit <= credit - WEIGHT_W'(1);
        end
    end
endmodule

module wrr_arbiter #(
    parameter int N        = 32,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic                ack,
    input  logic                wt_wr_en,
    input  logic [IDX_W-1:0]    wt_wr_idx,
    input  logic [WEIGHT_W-1:0] wt_wr_data,
    output logic [N-1:0]        gnt,
    output logic                gnt_valid,
    output logic [IDX_W-1:0]    gnt_id
`ifdef WRR_STATS_EN
    ,
    output logic [31:0]         stat_grant_cnt,
    output logic [15:0]         stat_reload_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RELOAD, GRANT} state_t;

    state_t                     state;
    logic [IDX_W-1:0]           ptr;
    logic [N-1:0][WEIGHT_W-1:0] weight;
    logic [N-1:0][WEIGHT_W-1:0] credit;
    logic [N-1:0]               elig;
    logic [N-1:0]               live;
    logic [N-1:0]               lane_wr;
    logic [N-1:0]               lane_charge;
    logic                       reload;
    logic [IDX_W-1:0]           sel;
    logic [IDX_W-1:0]           sel_hi;
    logic [IDX_W-1:0]           sel_lo;
    logic                       hi_found;
    logic                       lo_found;
    logic [IDX_W-1:0]           next_id;
    logic                       last_credit;

    assign reload = (state == RELOAD);

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            // Weight 0 masks a requester from both granting and reload triggering.
            assign elig[g]        = req[g] && credit[g] != '0 && weight[g] != '0;
            assign live[g]        = req[g] && weight[g] != '0;
            assign lane_wr[g]     = wt_wr_en && (wt_wr_idx == IDX_W'(g));
            assign lane_charge[g] = (state == GRANT) && ack && gnt[g];

            wrr_lane #(.WEIGHT_W(WEIGHT_W)) u_lane (
                .clk     (clk),
                .rst     (rst),
                .wr      (lane_wr[g]),
                .wr_data (wt_wr_data),
                .reload  (reload),
                .charge  (lane_charge[g]),
                .weight  (weight[g]),
                .credit  (credit[g])
            );
        end
    endgenerate

    // Rotating priority: first eligible at or above ptr, else first eligible overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i] && !lo_found) begin
                lo_found = 1'b1;
                sel_lo   = IDX_W'(i);
            end
            if (elig[i] && !hi_found && IDX_W'(i) >= ptr) begin
                hi_found = 1'b1;
                sel_hi   = IDX_W'(i);
            end
        end
        sel = hi_found ? sel_hi : sel_lo;
    end

    assign next_id     = (gnt_id == IDX_W'(N - 1)) ? '0 : gnt_id + IDX_W'(1);
    assign last_credit = (credit[gnt_id] <= WEIGHT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
`ifdef WRR_STATS_EN
            stat_grant_cnt  <= '0;
            stat_reload_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|elig) begin
                        gnt       <= N'(1) << sel;
                        gnt_valid <= 1'b1;
                        gnt_id    <= sel;
                        state     <= GRANT;
                    end else if (|live) begin
                        state <= RELOAD;
                    end
                end
                RELOAD: begin
`ifdef WRR_STATS_EN
                    stat_reload_cnt <= stat_reload_cnt + 16'd1;
`endif
                    state <= IDLE;
                end
                GRANT: begin
                    if (ack) begin
`ifdef WRR_STATS_EN
                        stat_grant_cnt <= stat_grant_cnt + 32'd1;
`endif
                        // Keep priority while the grantee still has credit left.
                        ptr       <= last_credit ? next_id : gnt_id;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (!req[gnt_id]) begin
                        ptr       <= next_id;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: reset, equal/weighted rotation, withdrawal,
// reset mid-grant and weight-0 masking, with hand-derived grant sequences.

module tb_wrr_arbiter;
    localparam int N        = 32;
    localparam int WEIGHT_W = 4;
    localparam int IDX_W    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req;
    logic                ack;
    logic                wt_wr_en;
    logic [IDX_W-1:0]    wt_wr_idx;
    logic [WEIGHT_W-1:0] wt_wr_data;
    logic [N-1:0]        gnt;
    logic                gnt_valid;
    logic [IDX_W-1:0]    gnt_id;
`ifdef WRR_STATS_EN
    logic [31:0]         stat_grant_cnt;
    logic [15:0]         stat_reload_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    wrr_arbiter #(.N(N), .WEIGHT_W(WEIGHT_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .wt_wr_en   (wt_wr_en),
        .wt_wr_idx  (wt_wr_idx),
        .wt_wr_data (wt_wr_data),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
`ifdef WRR_STATS_EN
        ,
        .stat_grant_cnt  (stat_grant_cnt),
        .stat_reload_cnt (stat_reload_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles waited: 1 for a direct grant, 3 when a RELOAD pass is needed
    // (IDLE decides reload, RELOAD loads credits, IDLE then grants).
    task automatic wait_grant(input int exp_id, input int exp_wait, input string tag);
        int w;
        w = 0;
        while (!gnt_valid && w < 10) begin
            step();
            w++;
        end
        chk({tag, "_wait"}, 64'(w), 64'(exp_wait));
        chk({tag, "_id"}, 64'(gnt_id), 64'(exp_id));
        chk({tag, "_gnt"}, 64'(gnt), 64'(1) << exp_id);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk({tag, "_bubble"}, 64'(gnt_valid), 64'd0);
    endtask

    task automatic wr_weight(input int idx, input int val);
        wt_wr_en   = 1'b1;
        wt_wr_idx  = IDX_W'(idx);
        wt_wr_data = WEIGHT_W'(val);
        step();
        wt_wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int rl_before;
        rst = 1'b1; req = '1; ack = 1'b0;
        wt_wr_en = 1'b0; wt_wr_idx = '0; wt_wr_data = '0;
        step(); step();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_valid", 64'(gnt_valid), 64'd0);
        chk("rst_id", 64'(gnt_id), 64'd0);

        // Equal weights: 0,1,2,3 then reload and wrap to 0,1.
        rst = 1'b0; req = 32'hF;
        wait_grant(0, 1, "eq0"); do_ack("eq0");
        wait_grant(1, 1, "eq1"); do_ack("eq1");
        wait_grant(2, 1, "eq2"); do_ack("eq2");
        wait_grant(3, 1, "eq3"); do_ack("eq3");
        wait_grant(0, 3, "eq4"); do_ack("eq4");
        wait_grant(1, 1, "eq5"); do_ack("eq5");

        // Weighted: weight0=3, weight1=1 -> 0,0,0,1,0,0,0,1.
        req = '0;
        wr_weight(0, 3);
        req = 32'h3;
        wait_grant(0, 3, "wt0"); do_ack("wt0");
        wait_grant(0, 1, "wt1"); do_ack("wt1");
        wait_grant(0, 1, "wt2"); do_ack("wt2");
        wait_grant(1, 1, "wt3"); do_ack("wt3");
        wait_grant(0, 3, "wt4"); do_ack("wt4");
        wait_grant(0, 1, "wt5"); do_ack("wt5");
        wait_grant(0, 1, "wt6"); do_ack("wt6");
        wait_grant(1, 1, "wt7"); do_ack("wt7");

        // Withdrawal: grant 5, drop req[5] -> clears, 6 next, credit5 untouched.
        req = (32'd1 << 5) | (32'd1 << 6);
        wait_grant(5, 1, "wd5");
        req = 32'd1 << 6;
        step();
        chk("wd_clear_valid", 64'(gnt_valid), 64'd0);
        chk("wd_clear_gnt", 64'(gnt), 64'd0);
        wait_grant(6, 1, "wd6"); do_ack("wd6");
        req = 32'd1 << 5;
        wait_grant(5, 1, "wd5_credit"); do_ack("wd5_credit");

        // Reset mid-grant on id 7.
        req = 32'd1 << 7;
        wait_grant(7, 1, "mr7");
        rst = 1'b1;
        step();
        chk("mr_gnt", 64'(gnt), 64'd0);
        chk("mr_valid", 64'(gnt_valid), 64'd0);
        chk("mr_id", 64'(gnt_id), 64'd0);
`ifdef WRR_STATS_EN
        chk("mr_stat_grant", 64'(stat_grant_cnt), 64'd0);
        chk("mr_stat_reload", 64'(stat_reload_cnt), 64'd0);
`endif
        rst = 1'b0;
        req = (32'd1 << 0) | (32'd1 << 7);
        wait_grant(0, 1, "mr_ptr0"); do_ack("mr_ptr0");
        req = 32'd1 << 5;
        wait_grant(5, 1, "mr_credit5"); do_ack("mr_credit5");

        // Masking: drain credit2, set weight2=0, hold req for 20 cycles.
        req = 32'd1 << 2;
        wait_grant(2, 1, "mk_drain"); do_ack("mk_drain");
        req = '0;
        wr_weight(2, 0);
        req = 32'd1 << 2;
`ifdef WRR_STATS_EN
        rl_before = int'(stat_reload_cnt);
`else
        rl_before = 0;
`endif
        seen = 0;
        repeat (20) begin
            step();
            if (gnt_valid) seen++;
        end
        chk("mk_nogrant", 64'(seen), 64'd0);
`ifdef WRR_STATS_EN
        chk("mk_noreload", 64'(stat_reload_cnt), 64'(rl_before));
`endif
        wr_weight(2, 2);
        wait_grant(2, 3, "mk_unmask");
        wr_weight(2, 5);
        chk("mk_wr_hold_valid", 64'(gnt_valid), 64'd1);
        chk("mk_wr_hold_id", 64'(gnt_id), 64'd2);
        do_ack("mk_unmask");
        wait_grant(2, 1, "mk_keep"); do_ack("mk_keep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
